// File: rtl/cnt_pkg.sv
// Shared constants and parameter legality check for the step counter family.
package cnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 1;
  localparam int MODE_SAT  = 0;

  // True when the width/modulus pair describes a buildable counter.
  function automatic bit params_legal(input int width, input int modulus);
    if (width < 1 || width > 16) return 1'b0;
    if (modulus < 2) return 1'b0;
    if (modulus > (1 << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the system_clk domain and emits a
// one-cycle pulse for each rising edge of that level.
module sync_edge_detect (
  input  logic system_clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic s1, s2, s3;

  // s1/s2 form the synchroniser, s3 remembers the previous synchronised level.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= level_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse_o = s2 & ~s3;

endmodule

// File: rtl/param_sync_counter.sv
// Parametrised up/down counter advanced by debounced key edges, with load,
// wrap/saturate mode, registered carry pulse and combinational terminal count.
module param_sync_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int WRAP    = 1
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             step_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_o,
  output logic             tc_o
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("param_sync_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             step_pulse;
  logic [WIDTH-1:0] count_q, count_nxt, load_clamped;
  logic             carry_q, carry_nxt;

  sync_edge_detect u_step_sync (
    .system_clk (system_clk),
    .reset      (reset),
    .level_i    (step_i),
    .pulse_o    (step_pulse)
  );

  assign load_clamped = (load_val_i > MAX_CNT) ? MAX_CNT : load_val_i;

  // Ends are detected before any arithmetic so MODULUS == 2**WIDTH never overflows.
  always_comb begin
    count_nxt = count_q;
    carry_nxt = 1'b0;
    if (load_i) begin
      count_nxt = load_clamped;
    end else if (step_pulse && en_i) begin
      case (up_i)
        DIR_UP: begin
          if (count_q == MAX_CNT) begin
            if (WRAP == MODE_WRAP) begin
              count_nxt = '0;
              carry_nxt = 1'b1;
            end
          end else begin
            count_nxt = count_q + ONE;
          end
        end
        DIR_DOWN: begin
          if (count_q == '0) begin
            if (WRAP == MODE_WRAP) begin
              count_nxt = MAX_CNT;
              carry_nxt = 1'b1;
            end
          end else begin
            count_nxt = count_q - ONE;
          end
        end
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_nxt;
      carry_q <= carry_nxt;
    end
  end

  assign count_o = count_q;
  assign carry_o = carry_q;
  assign tc_o    = (up_i == DIR_UP) ? (count_q == MAX_CNT) : (count_q == '0);

endmodule
